// File: rtl/module_despliegue_scan.sv
// Multiplexed seven-segment driver: captures a binary source, converts it to BCD by
// double-dabble, then scans the digits. Optional leading-zero blanking: DESPLIEGUE_BLANK_EN.
module module_despliegue_scan #(
  parameter int W        = 8,
  parameter int WA       = 4,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 27000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_a,
  input  logic                  load_b,
  input  logic                  load_m,
  input  logic [WA-1:0]         a_bin,
  input  logic [WA-1:0]         b_bin,
  input  logic [W-1:0]          mult_bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            catodo,
  output logic [DIGITS-1:0]     anodo
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = $clog2(W + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic bit digits_fit();
    longint p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((longint'(1) << W) - 1);
  endfunction

  if (!digits_fit()) begin : g_bad_digits
    $error("DIGITS too small to show every W-bit value");
  end
  if (WA > W) begin : g_bad_wa
    $error("WA must not exceed W");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("SCAN_DIV must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state;
  logic [W-1:0]  shreg;
  logic [BW-1:0] acc;
  logic [BW-1:0] acc_adj;
  logic [IW-1:0] iter;
  logic          load_any;
  logic [W-1:0]  load_val;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    load_any = load_a | load_b | load_m;
    load_val = '0;
    if (load_m)      load_val = mult_bin;
    else if (load_b) load_val = W'(b_bin);
    else if (load_a) load_val = W'(a_bin);
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // A load in any state restarts the conversion, so a superseded value never commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      iter    <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (load_any) begin
        state <= CONV;
        shreg <= load_val;
        acc   <= '0;
        iter  <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: busy <= 1'b0;
          CONV: begin
            acc   <= {acc_adj[BW-2:0], shreg[W-1]};
            shreg <= shreg << 1;
            iter  <= iter + 1'b1;
            if (iter == IW'(W - 1)) state <= COMMIT;
          end
          COMMIT: begin
            bcd_out <= acc;
            done    <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [PW-1:0] presc;
  logic [XW-1:0] idx;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg;

  always_comb begin
    logic zero_above;
    nib        = '0;
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (bcd_out[4*i +: 4] == 4'd0);
      if (XW'(i) == idx) begin
        nib = bcd_out[4*i +: 4];
`ifdef DESPLIEGUE_BLANK_EN
        blank = (i != 0) && zero_above;
`else
        blank = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    if (blank) seg = 7'h7F;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      idx    <= '0;
      anodo  <= '1;
      catodo <= 7'h7F;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == XW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      anodo  <= ~(DIGITS'(1) << idx);
      catodo <= seg;
    end
  end

endmodule

// File: tb/tb_module_despliegue_scan.sv
// Self-checking bench: randomized loads against a decimal-arithmetic model of the
// display value, latency and scan position, plus hand-computed literal checks.
module tb_module_despliegue_scan;

  localparam int W = 8, WA = 4, DIGITS = 3, SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_a = 1'b0, load_b = 1'b0, load_m = 1'b0;
  logic [WA-1:0] a_bin = '0, b_bin = '0;
  logic [W-1:0]  mult_bin = '0;
  logic busy, done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [6:0] catodo;
  logic [DIGITS-1:0] anodo;

  always #5 clk = ~clk;

  module_despliegue_scan #(.W(W), .WA(WA), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .load_a(load_a), .load_b(load_b), .load_m(load_m),
    .a_bin(a_bin), .b_bin(b_bin), .mult_bin(mult_bin),
    .busy(busy), .done(done), .bcd_out(bcd_out), .catodo(catodo), .anodo(anodo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input int dig);
    case (dig)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_cat(input int val, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef DESPLIEGUE_BLANK_EN
    if (d > 0 && val < p) return 7'h7F;
`endif
    return seg_of((val / p) % 10);
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int val);
    logic [4*DIGITS-1:0] r;
    int v;
    r = '0;
    v = val;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Model: a load starts a W+1-edge countdown; the value appears when it expires.
  int   disp_val = 0, pend_val = 0, pend_age = 0, edge_n = 0, cur_digit = 0;
  bit   pend_valid = 0;
  logic exp_busy = 1'b0, exp_done = 1'b0;
  logic [DIGITS-1:0] exp_an = '1;
  logic [6:0] exp_cat = 7'h7F;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val = 0; pend_valid = 0; pend_age = 0; edge_n = 0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_an = '1; exp_cat = 7'h7F;
    end else begin
      cur_digit = (edge_n / SCAN_DIV) % DIGITS;
      edge_n++;
      exp_an  = ~(DIGITS'(1) << cur_digit);
      exp_cat = model_cat(disp_val, cur_digit);
      exp_done = 1'b0;
      if (load_m || load_b || load_a) begin
        pend_val   = load_m ? int'(mult_bin) : (load_b ? int'(b_bin) : int'(a_bin));
        pend_age   = 0;
        pend_valid = 1;
      end else if (pend_valid) begin
        pend_age++;
        if (pend_age == W + 1) begin
          disp_val   = pend_val;
          exp_done   = 1'b1;
          pend_valid = 0;
        end
      end
      exp_busy = pend_valid || exp_done;
    end
  end

  int done_cnt = 0;
  bit seen_123 = 0;

  always @(posedge clk) begin
    #2;
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("bcd_out", bcd_out, to_bcd(disp_val));
    check("anodo", anodo, exp_an);
    check("catodo", catodo, exp_cat);
    if (done) done_cnt++;
    if (bcd_out == 12'h123) seen_123 = 1;
  end

  task automatic pulse_load(input logic la, input logic lb, input logic lm,
                            input logic [WA-1:0] a, input logic [WA-1:0] b, input logic [W-1:0] m);
    @(negedge clk);
    load_a = la; load_b = lb; load_m = lm; a_bin = a; b_bin = b; mult_bin = m;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; load_m = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #3;
      if (done) begin
        lat = c;
        break;
      end
    end
    check(name, lat, W + 1);
  endtask

  int vals[6] = '{255, 0, 9, 10, 99, 100};
  logic [11:0] bcds[6] = '{12'h255, 12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
  logic [2:0] an_seq[3] = '{3'b110, 3'b101, 3'b011};
  logic [6:0] cat_seq[3];

  initial begin
    int run;
    bit found;
    logic [2:0] prev_an;
`ifdef DESPLIEGUE_BLANK_EN
    cat_seq = '{7'h24, 7'h19, 7'h7F};
`else
    cat_seq = '{7'h24, 7'h19, 7'h40};
`endif

    repeat (3) @(posedge clk);
    #3;
    check("rst_catodo", catodo, 7'h7F);
    check("rst_anodo", anodo, 3'b111);
    check("rst_bcd", bcd_out, 12'h000);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      pulse_load(1'b0, 1'b0, 1'b1, '0, '0, W'(vals[i]));
      check("busy_after_load", busy, 1'b1);
      wait_done("conv_latency");
      check("conv_value", bcd_out, 32'(bcds[i]));
    end

    pulse_load(1'b1, 1'b0, 1'b1, 4'd9, '0, 8'd200);
    wait_done("prio_latency");
    check("prio_value", bcd_out, 12'h200);

    done_cnt = 0;
    seen_123 = 0;
    pulse_load(1'b0, 1'b0, 1'b1, '0, '0, 8'd123);
    @(negedge clk);
    pulse_load(1'b1, 1'b0, 1'b0, 4'd7, '0, '0);
    wait_done("abort_latency");
    repeat (15) @(posedge clk);
    #3;
    check("abort_done_count", done_cnt, 1);
    check("abort_never_123", seen_123, 1'b0);
    check("abort_value", bcd_out, 12'h007);

    pulse_load(1'b0, 1'b0, 1'b1, '0, '0, 8'd42);
    wait_done("scan_latency");
    found = 0;
    prev_an = anodo;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #3;
      if (anodo == 3'b110 && prev_an != 3'b110) begin
        found = 1;
        break;
      end
      prev_an = anodo;
    end
    check("scan_found_digit0", found, 1'b1);
    for (int d = 0; d < 3; d++) begin
      check("scan_anodo", anodo, an_seq[d]);
      check("scan_catodo", catodo, cat_seq[d]);
      run = 0;
      for (int c = 0; c < 20; c++) begin
        run++;
        @(posedge clk); #3;
        if (anodo != an_seq[d]) break;
      end
      check("scan_dwell", run, SCAN_DIV);
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      load_a   = ($urandom_range(0, 9) == 0);
      load_b   = ($urandom_range(0, 9) == 0);
      load_m   = ($urandom_range(0, 9) == 0);
      a_bin    = WA'($urandom);
      b_bin    = WA'($urandom);
      mult_bin = W'($urandom);
    end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; load_m = 1'b0;
    repeat (15) @(posedge clk);

    pulse_load(1'b0, 1'b0, 1'b1, '0, '0, 8'd77);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_bcd", bcd_out, 12'h000);
    check("midrst_catodo", catodo, 7'h7F);
    check("midrst_anodo", anodo, 3'b111);
    done_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_bcd_stays", bcd_out, 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
